// File: rtl/erode.sv
// erode: binary 3x3 morphological erosion on a binarised video stream.
// Pixels are qualified by the VTC horizontal/vertical counters. Two line
// buffers and a three-column window feed the erosion kernel. The eroded
// pixel for centre (h-1, v-1) appears one PCLK after pixel (h, v).
// Build option: define ERODE_CROSS_EN to use the 5-point cross structuring
// element instead of the default full 3x3 square.
module erode #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480
) (
  input  logic        PCLK,
  input  logic        rst_n,
  input  logic [11:0] VtcHCnt,
  input  logic [11:0] VtcVCnt,
  input  logic        pix_i,
  output logic        pix_o,
  output logic        vld_o
);

  localparam int          AW    = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam logic [11:0] H_LIM = 12'(H_ACT);
  localparam logic [11:0] V_LIM = 12'(V_ACT);

  // Stage p0: counter decode, line buffer read, new column assembly
  logic          h_in_p0;
  logic          v_in_p0;
  logic          active_p0;
  logic          h_ge1_p0;
  logic          h_ge2_p0;
  logic          v_ge1_p0;
  logic          v_ge2_p0;
  logic          row0_p0;
  logic [AW-1:0] addr_p0;
  logic          lb0_rd_p0;
  logic          lb1_rd_p0;
  logic [2:0]    new_col_p0;
  logic          erode_p0;
  logic          emit_p0;

  // Line buffers: lb0 holds row v-1, lb1 holds row v-2. No reset on purpose;
  // stale contents are hidden by the row masking and frame_ok.
  logic          lb0 [H_ACT];
  logic          lb1 [H_ACT];

  // Stage p1: window columns (col1 = h-1, col2 = h-2) and control state
  logic [2:0]    col1_p1;
  logic [2:0]    col2_p1;
  logic          frame_ok;

  // Erosion kernel over the window. Column bit order: [2] row v-2 (top),
  // [1] row v-1 (centre row), [0] row v (bottom).
  function automatic logic erode_win(input logic [2:0] c2,
                                     input logic [2:0] c1,
                                     input logic [2:0] cn);
`ifdef ERODE_CROSS_EN
    logic unused_corners;
    unused_corners = c2[2] ^ c2[0] ^ cn[2] ^ cn[0];
    return (&c1) & c2[1] & cn[1] & (unused_corners | 1'b1);
`else
    return (&c2) & (&c1) & (&cn);
`endif
  endfunction

  // Counters are compared unsigned; a pixel is active only when both are in range
  assign h_in_p0   = (VtcHCnt < H_LIM);
  assign v_in_p0   = (VtcVCnt < V_LIM);
  assign active_p0 = h_in_p0 & v_in_p0;

  assign h_ge1_p0  = (VtcHCnt >= 12'd1);
  assign h_ge2_p0  = (VtcHCnt >= 12'd2);
  assign v_ge1_p0  = (VtcVCnt >= 12'd1);
  assign v_ge2_p0  = (VtcVCnt >= 12'd2);
  assign row0_p0   = (VtcVCnt == 12'd0);

  // Only used on active cycles, where VtcHCnt < H_ACT fits in AW bits
  assign addr_p0   = VtcHCnt[AW-1:0];

  assign lb0_rd_p0 = lb0[addr_p0];
  assign lb1_rd_p0 = lb1[addr_p0];

  assign new_col_p0 = {lb1_rd_p0, lb0_rd_p0, pix_i};

  assign erode_p0  = erode_win(col2_p1, col1_p1, new_col_p0);

  // Border centres (column 0 / row 0) and anything built from a frame that
  // started before the last reset are forced to 0
  assign emit_p0   = active_p0 & h_ge2_p0 & v_ge2_p0 & frame_ok;

  // Line buffer update: read-before-write at the same address on active cycles
  always_ff @(posedge PCLK) begin
    if (active_p0) begin
      lb1[addr_p0] <= lb0_rd_p0;
      lb0[addr_p0] <= pix_i;
    end
  end

  // Window shift on active cycles; holds during blanking
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      col1_p1 <= 3'b000;
      col2_p1 <= 3'b000;
    end else if (active_p0) begin
      col2_p1 <= col1_p1;
      col1_p1 <= new_col_p0;
    end
  end

  // frame_ok latches once a row-0 pixel has been sampled after reset
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      frame_ok <= 1'b0;
    end else if (active_p0 && row0_p0) begin
      frame_ok <= 1'b1;
    end
  end

  // Registered outputs: masked erosion result and centre-valid flag
  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      pix_o <= 1'b0;
      vld_o <= 1'b0;
    end else begin
      pix_o <= emit_p0 ? erode_p0 : 1'b0;
      vld_o <= active_p0 & h_ge1_p0 & v_ge1_p0;
    end
  end

endmodule
